// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi
//   Seconds/minutes/hours/day timekeeper with NA independently settable
//   alarms, each gated by a per-day enable mask. A ring/snooze FSM drives the
//   buzzer with a ring timeout and a limit on snoozes per trigger. All state
//   advances on the system clock, time fields only on the one-cycle 1 Hz tick.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   tick                 one-cycle strobe, once per second
//   time_set, alarm_set  mode buttons (both high behaves as normal running)
//   alarm_sel            alarm shown on the display / being edited
//   min_adv/hrs_adv/day_adv  advance buttons, applied on tick
//   alarm_en             per-alarm arm
//   day_mask             bit k*ND+d allows alarm k on day d
//   snooze, stop         level requests, sampled every clk
//   sec/min/hrs/day      current time (registered)
//   disp_min/disp_hrs    value for the lcd drivers (time, or selected alarm)
//   buzz                 alarm sounding
//   active_alarm         index of the ringing/snoozed alarm (held in IDLE)
//   alarm_state          0=IDLE 1=RING 2=SNOOZE
module alarm_clock_multi #(
  parameter int NS         = 60,
  parameter int NH         = 24,
  parameter int ND         = 7,
  parameter int NA         = 4,
  parameter int RING_S     = 60,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int W          = 7,
  localparam int SW        = (NA > 1) ? $clog2(NA) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               time_set,
  input  logic               alarm_set,
  input  logic [SW-1:0]      alarm_sel,
  input  logic               min_adv,
  input  logic               hrs_adv,
  input  logic               day_adv,
  input  logic [NA-1:0]      alarm_en,
  input  logic [NA*ND-1:0]   day_mask,
  input  logic               snooze,
  input  logic               stop,
  output logic [W-1:0]       sec,
  output logic [W-1:0]       min,
  output logic [W-1:0]       hrs,
  output logic [W-1:0]       day,
  output logic [W-1:0]       disp_min,
  output logic [W-1:0]       disp_hrs,
  output logic               buzz,
  output logic [SW-1:0]      active_alarm,
  output logic [1:0]         alarm_state
);

  localparam logic [W-1:0] SEC_LAST = W'(NS - 1);
  localparam logic [W-1:0] MIN_LAST = W'(NS - 1);
  localparam logic [W-1:0] HRS_LAST = W'(NH - 1);
  localparam logic [W-1:0] DAY_LAST = W'(ND - 1);

  localparam int RW = $clog2(RING_S + 1);
  localparam int ZW = $clog2(SNOOZE_S + 1);
  localparam int CW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_S - 1);
  localparam logic [ZW-1:0] SNZ_LOAD  = ZW'(SNOOZE_S);
  localparam logic [CW-1:0] SNZ_MAX   = CW'(MAX_SNOOZE);
  localparam logic [SW:0]   NA_L      = (SW + 1)'(NA);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  function automatic logic [W-1:0] inc_mod(input logic [W-1:0] v,
                                           input logic [W-1:0] last);
    return (v == last) ? '0 : v + W'(1);
  endfunction

  // Mode decode: both buttons together fall back to running.
  logic tset, aset, run;
  assign tset = time_set & ~alarm_set;
  assign aset = alarm_set & ~time_set;
  assign run  = ~(tset | aset);

  // Running-mode successor of the current time, with the carry chain.
  logic         sec_wrap, min_wrap, hrs_wrap;
  logic [W-1:0] sec_next, min_next, hrs_next, day_next;
  assign sec_wrap = (sec == SEC_LAST);
  assign min_wrap = sec_wrap & (min == MIN_LAST);
  assign hrs_wrap = min_wrap & (hrs == HRS_LAST);
  assign sec_next = inc_mod(sec, SEC_LAST);
  assign min_next = sec_wrap ? inc_mod(min, MIN_LAST) : min;
  assign hrs_next = min_wrap ? inc_mod(hrs, HRS_LAST) : hrs;
  assign day_next = hrs_wrap ? inc_mod(day, DAY_LAST) : day;

  // Timekeeper. Setting mode freezes seconds and advances fields without carry;
  // alarm-set mode keeps time running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec <= '0;
      min <= '0;
      hrs <= '0;
      day <= '0;
    end else if (tick) begin
      if (tset) begin
        if (min_adv) min <= inc_mod(min, MIN_LAST);
        if (hrs_adv) hrs <= inc_mod(hrs, HRS_LAST);
        if (day_adv) day <= inc_mod(day, DAY_LAST);
      end else begin
        sec <= sec_next;
        min <= min_next;
        hrs <= hrs_next;
        day <= day_next;
      end
    end
  end

  // One-hot of the post-increment day, shared by every alarm's mask check.
  logic [ND-1:0] day_onehot;
  genvar gi;
  for (gi = 0; gi < ND; gi++) begin : g_day
    assign day_onehot[gi] = (day_next == W'(gi));
  end

  logic [W-1:0] amin [NA];
  logic [W-1:0] ahrs [NA];
  logic [NA-1:0] match;

  for (gi = 0; gi < NA; gi++) begin : g_alarm
    logic [W-1:0] amin_reg, ahrs_reg;
    logic         edit;

    // An out-of-range alarm_sel matches no slot, so its edits are dropped.
    assign edit = tick & aset & (alarm_sel == SW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        amin_reg <= '0;
        ahrs_reg <= '0;
      end else if (edit) begin
        if (min_adv) amin_reg <= inc_mod(amin_reg, MIN_LAST);
        if (hrs_adv) ahrs_reg <= inc_mod(ahrs_reg, HRS_LAST);
      end
    end

    assign amin[gi]  = amin_reg;
    assign ahrs[gi]  = ahrs_reg;
    // Compared against the time the clock is about to show, so the buzzer
    // rises on the same edge the seconds roll to zero.
    assign match[gi] = alarm_en[gi]
                     & (|(day_mask[gi*ND +: ND] & day_onehot))
                     & (hrs_next == ahrs_reg)
                     & (min_next == amin_reg);
  end

  // Lowest-numbered matching alarm wins.
  logic [SW-1:0] hit_idx;
  always_comb begin
    hit_idx = '0;
    for (int i = NA - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = SW'(i);
    end
  end

  logic trigger;
  assign trigger = tick & run & sec_wrap & (|match);

  logic sel_ok;
  assign sel_ok = ({1'b0, alarm_sel} < NA_L);

  always_comb begin
    disp_min = min;
    disp_hrs = hrs;
    if (aset) begin
      disp_min = '0;
      disp_hrs = '0;
      if (sel_ok) begin
        disp_min = amin[alarm_sel];
        disp_hrs = ahrs[alarm_sel];
      end
    end
  end

  state_t        state;
  logic [RW-1:0] ring_cnt;
  logic [ZW-1:0] snz_cnt;
  logic [CW-1:0] snooze_cnt;

  // Ring/snooze FSM. Order of precedence: mode entry, disarm of the active
  // alarm, stop, snooze, then tick-driven timeout/expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      buzz         <= 1'b0;
      active_alarm <= '0;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      snooze_cnt   <= '0;
    end else if (tset | aset) begin
      state <= ST_IDLE;
      buzz  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state        <= ST_RING;
            buzz         <= 1'b1;
            active_alarm <= hit_idx;
            ring_cnt     <= '0;
            snooze_cnt   <= '0;
          end
        end
        ST_RING: begin
          if (!alarm_en[active_alarm] || stop) begin
            state <= ST_IDLE;
            buzz  <= 1'b0;
          end else if (snooze && (snooze_cnt < SNZ_MAX)) begin
            state      <= ST_SNOOZE;
            buzz       <= 1'b0;
            snz_cnt    <= SNZ_LOAD;
            snooze_cnt <= snooze_cnt + CW'(1);
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              state <= ST_IDLE;
              buzz  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RW'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (!alarm_en[active_alarm] || stop) begin
            state <= ST_IDLE;
            buzz  <= 1'b0;
          end else if (tick) begin
            if (snz_cnt == ZW'(1)) begin
              state    <= ST_RING;
              buzz     <= 1'b1;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt - ZW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          buzz  <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_state = state;

endmodule
